vc_pmem_arbiter: RTL
====================

# vc_pmem_arbiter

Arbiter and sequencer for the single physical-memory port shared by L2 fill reads and victim-cache dirty writebacks. It sits between the L2/victim-cache pair and pmem, accepts one request from each side, grants one at a time, and drives the pmem handshake. It returns fill data or an acknowledge to the winner, and keeps L2 reads ordered behind any writeback to the same line.

## Interface
- STARVE_MAX, 4: consecutive L2 grants allowed while a VC writeback waits (only used with the fairness macro).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- l2_read  in  1  L2 fill request; held until `l2_ack`.
- l2_address  in  12  line address of the fill.
- l2_rdata  out  128  fill data, valid while `l2_ack`=1.
- l2_ack  out  1  one-cycle fill-complete pulse.
- vc_write  in  1  VC dirty-writeback request; held until `vc_ack`.
- vc_address  in  12  writeback line address.
- vc_wdata  in  128  writeback line data.
- vc_ack  out  1  one-cycle writeback-complete pulse.
- pmem_read  out  1  pmem read command.
- pmem_write  out  1  pmem write command.
- pmem_address  out  12  pmem line address.
- pmem_wdata  out  128  pmem write data.
- pmem_rdata  in  128  pmem read data.
- pmem_resp  in  1  pmem completion; one cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- Four states:
  - IDLE: no request active; arbitrates.
  - RD: drives `pmem_read`=1, `pmem_address`=latched address.
  - WR: drives `pmem_write`=1, `pmem_address`/`pmem_wdata` = latched address/data.
  - ACK: pulses the winner's ack for one cycle.
- Arbitration in IDLE, by priority:
  1. Only one request high: that request wins.
  2. Both high and `l2_address`==`vc_address` (hazard): the VC writeback wins, so L2 never reads stale memory.
  3. Both high, otherwise: L2 wins, subject to the fairness rule in Configuration.
- The winner's address and data are latched into registers on the grant edge. Inputs are not re-sampled until the next IDLE.
- RD: on `pmem_resp`=1, latch `pmem_rdata` into `l2_rdata` and go to ACK with owner=L2.
- WR: on `pmem_resp`=1, go to ACK with owner=VC.
- ACK: the owner's ack is 1, the other ack is 0; go to IDLE unconditionally. Requesters drop their request in the ACK cycle.
- `pmem_read` and `pmem_write` are never high together. Both are low in IDLE and ACK.
- `pmem_resp` seen in IDLE or ACK is ignored.
- Address compare is on all 12 bits. No arithmetic on addresses.

## Timing
- All outputs decode from registered state and latched data; no combinational input-to-output path.
- Request high at edge N in IDLE: RD/WR state and pmem command from cycle N+1.
- `pmem_resp` at edge K: ack high in cycle K+1, IDLE at K+2, earliest next grant at K+2.
- Minimum request-to-ack: 2 cycles plus pmem latency.
- Reset values: state=IDLE. `l2_ack`, `vc_ack`, `pmem_read`, `pmem_write`, `busy` = 0. `pmem_address`=0, `pmem_wdata`=0, `l2_rdata`=0. Starvation counter = 0.
- Reset mid-transfer aborts the pmem command immediately. No ack is issued. pmem must be reset in the same domain.

## Configuration
- `VC_ARB_FAIRNESS_EN` defined: a saturating 3-bit counter counts L2 grants issued while `vc_write` is high.
  - The counter clears on any VC grant, and on any IDLE arbitration where `vc_write`=0.
  - When the counter == STARVE_MAX and both requests are high, VC wins regardless of priority.
- `VC_ARB_FAIRNESS_EN` undefined: strict L2 priority except for the same-address hazard. The counter is not built.

## Structure
- Add to the shared `lc3b_types` package: `typedef enum {IDLE, RD, WR, ACK} vc_arb_state_t`, an owner enum `{OWN_L2, OWN_VC}`, and `localparam` line-address width 12.
- One sub-module: `vc_arb_age_ctr`, the starvation counter. It is instantiated only under `VC_ARB_FAIRNESS_EN`.

## Test plan
- Reset then `l2_read`=1, addr 0x0A3, pmem responds after 3 cycles with data D -> `pmem_read`=1 at address 0x0A3 for 3 cycles, then `l2_ack`=1 with `l2_rdata`=D for exactly one cycle.
- `vc_write`=1, addr 0x010, data W -> `pmem_write`=1 with 0x010/W, then `vc_ack` one cycle after `pmem_resp`; `l2_ack` stays 0.
- Both requests high, addresses 0x020 and 0x021 -> L2 served first, then VC; the second grant occurs 2 cycles after the first `pmem_resp`.
- Both requests high, same address 0x055 -> WR first, then RD at 0x055.
- With `VC_ARB_FAIRNESS_EN`, `vc_write` held and `l2_read` re-asserted each time -> exactly 4 RD grants, then one WR. Without the macro -> no WR while `l2_read` stays high.
- `rst_n` low during RD -> `pmem_read`, `busy` and both acks at 0 immediately, state IDLE; after release, a fresh request completes normally.

Source files
------------

// File: rtl/lc3b_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lc3b_types (package)
//  Description : Shared LC-3b memory-hierarchy types. Holds the line-address
//                width and the state/owner encodings used by the physical
//                memory arbiter that sits between the L2 and victim cache.
//  Revision    : 1.0  initial release
// ============================================================================
package lc3b_types;

    localparam int c_line_addr_w = 12;
    localparam int c_line_data_w = 128;
    localparam int c_age_w       = 3;

    typedef logic [c_line_addr_w-1:0] line_addr_t;
    typedef logic [c_line_data_w-1:0] line_data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        ACK  = 2'd3
    } vc_arb_state_t;

    typedef enum logic {
        OWN_L2 = 1'b0,
        OWN_VC = 1'b1
    } vc_arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/vc_arb_age_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : vc_arb_age_ctr
//  Description : Saturating starvation counter. Counts L2 grants handed out
//                while a victim-cache writeback is waiting; clear wins over
//                increment.
//  Revision    : 1.0  initial release
// ============================================================================
module vc_arb_age_ctr #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Saturate at all-ones so a long L2 burst cannot wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/vc_pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vc_pmem_arbiter
//  Description : Arbitrates the single pmem port between L2 fill reads and
//                victim-cache dirty writebacks. One transfer at a time;
//                a writeback to the same line as a pending fill goes first.
//                Optional anti-starvation for writebacks is enabled with the
//                VC_ARB_FAIRNESS_EN macro.
//  Revision    : 1.0  initial release
// ============================================================================
module vc_pmem_arbiter
    import lc3b_types::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    // L2 fill side
    input  logic         l2_read,
    input  logic [11:0]  l2_address,
    output logic [127:0] l2_rdata,
    output logic         l2_ack,
    // victim-cache writeback side
    input  logic         vc_write,
    input  logic [11:0]  vc_address,
    input  logic [127:0] vc_wdata,
    output logic         vc_ack,
    // physical memory
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [11:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic         busy
);

    localparam logic [c_age_w-1:0] c_starve_max = c_age_w'(STARVE_MAX);

    vc_arb_state_t     r_state;
    vc_arb_owner_t     r_owner;
    line_addr_t        r_addr;
    line_data_t        r_wdata;
    line_data_t        r_rdata;
    logic              r_l2_ack;
    logic              r_vc_ack;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic              r_busy;

    logic              w_hazard;
    logic              w_starved;
    logic              w_fair_en;
    logic              w_grant_vc;
    logic              w_grant_l2;
    logic [c_age_w-1:0] w_age_count;

    // Same-line hazard: writeback must land before the fill reads the line.
    assign w_hazard   = (l2_address == vc_address);

    // Writeback wins when alone, on a hazard, or when it has waited too long.
    assign w_starved  = w_fair_en && (w_age_count == c_starve_max);
    assign w_grant_vc = vc_write && (!l2_read || w_hazard || w_starved);
    assign w_grant_l2 = l2_read && !w_grant_vc;

`ifdef VC_ARB_FAIRNESS_EN
    logic w_age_inc;
    logic w_age_clr;

    // Count L2 wins that happen while a writeback is waiting; reset the age
    // whenever the writeback is served or nobody is waiting.
    assign w_fair_en = 1'b1;
    assign w_age_inc = (r_state == IDLE) && w_grant_l2 && vc_write;
    assign w_age_clr = (r_state == IDLE) && (w_grant_vc || !vc_write);

    vc_arb_age_ctr #(
        .CNT_W   (c_age_w)
    ) u_age_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_age_inc),
        .i_clr   (w_age_clr),
        .o_count (w_age_count)
    );
`else
    // Strict L2 priority: no age tracking, starvation never asserts.
    assign w_fair_en   = 1'b0;
    assign w_age_count = '0;
`endif

    // Transfer sequencer: grant in IDLE, hold the pmem command until the
    // response, then a single ACK cycle back to the winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_L2;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_l2_ack     <= 1'b0;
            r_vc_ack     <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_l2_ack <= 1'b0;
            r_vc_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_vc) begin
                        r_state      <= WR;
                        r_owner      <= OWN_VC;
                        r_addr       <= vc_address;
                        r_wdata      <= vc_wdata;
                        r_pmem_write <= 1'b1;
                        r_busy       <= 1'b1;
                    end else if (w_grant_l2) begin
                        r_state      <= RD;
                        r_owner      <= OWN_L2;
                        r_addr       <= l2_address;
                        r_pmem_read  <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                RD: begin
                    if (pmem_resp) begin
                        r_state     <= ACK;
                        r_rdata     <= pmem_rdata;
                        r_pmem_read <= 1'b0;
                        r_l2_ack    <= (r_owner == OWN_L2);
                        r_vc_ack    <= (r_owner == OWN_VC);
                    end
                end
                WR: begin
                    if (pmem_resp) begin
                        r_state      <= ACK;
                        r_pmem_write <= 1'b0;
                        r_l2_ack     <= (r_owner == OWN_L2);
                        r_vc_ack     <= (r_owner == OWN_VC);
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign l2_rdata     = r_rdata;
    assign l2_ack       = r_l2_ack;
    assign vc_ack       = r_vc_ack;
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_addr;
    assign pmem_wdata   = r_wdata;
    assign busy         = r_busy;

endmodule
`default_nettype wire
